// File: rtl/frame_sync_pkg.sv
// frame_sync shared types and constants.
// Sync word layout and FSM state encoding.
package frame_sync_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int SYNC_LEN = 4;
  localparam logic [SYNC_LEN-1:0] SYNC_WORD = 4'b1011;

endpackage

// File: rtl/frame_sync_payload_deser.sv
// Payload deserializer: MSB-first shift register
// with a load strobe producing a word and a valid pulse.
module frame_sync_payload_deser #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_shift,
  input  logic         i_bit,
  input  logic         i_load,
  output logic [W-1:0] o_data,
  output logic         o_valid
);

  logic [W-2:0] r_sr;
  logic [W-1:0] r_data;
  logic         r_valid;
  logic [W-1:0] w_word;

  assign w_word = {r_sr, i_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_shift) r_sr <= w_word[W-2:0];
      if (i_load)  r_data <= w_word;
      r_valid <= i_load;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/frame_sync.sv
// Frame synchronizer: locks onto periodic 1011 sync words,
// flywheels through isolated misses, deserializes payloads.
module frame_sync
  import frame_sync_pkg::*;
#(
  parameter int FRAME_LEN  = 16,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  localparam int PAY_LEN   = FRAME_LEN - SYNC_LEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x,
  input  logic               match,
  output logic               locked,
  output logic [1:0]         state,
  output logic [PAY_LEN-1:0] pay_data,
  output logic               pay_valid,
  output logic               sync_miss
);

  localparam int POS_W  = $clog2(FRAME_LEN);
  localparam int HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(FRAME_LEN - 1);
  localparam logic [POS_W-1:0]  POS_PLAST = POS_W'(PAY_LEN - 1);
  localparam logic [POS_W-1:0]  POS_PLEN  = POS_W'(PAY_LEN);
  localparam logic [HIT_W-1:0]  HIT_LOCK  = HIT_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_DROP = MISS_W'(UNLOCK_CNT);

  state_e            r_state;
  logic [POS_W-1:0]  r_pos;
  logic [HIT_W-1:0]  r_hit;
  logic [MISS_W-1:0] r_miss;
  logic              r_sync_miss;

  state_e            w_state_nxt;
  logic [POS_W-1:0]  w_pos_nxt;
  logic [HIT_W-1:0]  w_hit_nxt;
  logic [MISS_W-1:0] w_miss_nxt;
  logic              w_miss_p;

  logic              w_at_end;
  logic [POS_W-1:0]  w_pos_inc;
  logic [HIT_W-1:0]  w_hit_inc;
  logic [MISS_W-1:0] w_miss_inc;
  logic              w_shift;
  logic              w_load;

  assign w_at_end   = (r_pos == POS_LAST);
  assign w_pos_inc  = w_at_end ? '0 : r_pos + POS_W'(1);
  assign w_hit_inc  = r_hit + HIT_W'(1);
  assign w_miss_inc = r_miss + MISS_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_pos       <= '0;
      r_hit       <= '0;
      r_miss      <= '0;
      r_sync_miss <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pos       <= w_pos_nxt;
      r_hit       <= w_hit_nxt;
      r_miss      <= w_miss_nxt;
      r_sync_miss <= w_miss_p;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_hit_nxt   = r_hit;
    w_miss_nxt  = r_miss;
    w_miss_p    = 1'b0;
    unique case (r_state)
      HUNT: begin
        w_pos_nxt = '0;
        if (match) begin
          w_hit_nxt  = HIT_W'(1);
          w_miss_nxt = '0;
          if (LOCK_CNT == 1) w_state_nxt = LOCKED;
          else               w_state_nxt = VERIFY;
        end
      end
      VERIFY: begin
        w_pos_nxt = w_pos_inc;
        if (w_at_end) begin
          if (match) begin
            w_hit_nxt = w_hit_inc;
            if (w_hit_inc == HIT_LOCK) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = '0;
            end
          end else begin
            w_miss_p    = 1'b1;
            w_state_nxt = HUNT;
            w_pos_nxt   = '0;
            w_hit_nxt   = '0;
          end
        end
      end
      LOCKED: begin
        w_pos_nxt = w_pos_inc;
        if (w_at_end) begin
          if (match) begin
            w_miss_nxt = '0;
          end else begin
            w_miss_p   = 1'b1;
            w_miss_nxt = w_miss_inc;
            if (w_miss_inc == MISS_DROP) begin
              w_state_nxt = HUNT;
              w_pos_nxt   = '0;
              w_hit_nxt   = '0;
              w_miss_nxt  = '0;
            end
          end
        end
      end
      default: begin
        w_state_nxt = HUNT;
        w_pos_nxt   = '0;
        w_hit_nxt   = '0;
        w_miss_nxt  = '0;
      end
    endcase
  end

  // Capture only in LOCKED; state never changes mid-payload.
  always_comb begin
    w_shift = 1'b0;
    w_load  = 1'b0;
    if (r_state == LOCKED && r_pos < POS_PLEN) begin
      w_shift = 1'b1;
      w_load  = (r_pos == POS_PLAST);
    end
  end

  frame_sync_payload_deser #(
    .W(PAY_LEN)
  ) u_deser (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_shift (w_shift),
    .i_bit   (x),
    .i_load  (w_load),
    .o_data  (pay_data),
    .o_valid (pay_valid)
  );

  assign locked    = (r_state == LOCKED);
  assign state     = r_state;
  assign sync_miss = r_sync_miss;

endmodule
